// File: rtl/otp_agent_pkg.sv
// Shared types and defaults for the OTP guard agent that sits between the core
// RAM master port and the OTP/RAM slave.
package otp_agent_pkg;

  typedef enum logic [2:0] {
    BOOT_REQ  = 3'd0,
    BOOT_WAIT = 3'd1,
    PASS      = 3'd2,
    CHK_REQ   = 3'd3,
    CHK_WAIT  = 3'd4,
    PROG      = 3'd5
  } state_t;

  localparam int          DEF_BUS_WIDTH  = 32;
  localparam int          DEF_DATA_WIDTH = 32;
  localparam logic [31:0] DEF_DBG_MAGIC  = 32'hD5B6_0A11;

  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/otp_agent_rdwait.sv
// Slave read-latency timer shared by the boot read and the blank-check read.
// Load with start; done pulses in the cycle the slave read data is valid.
module otp_agent_rdwait #(
  parameter int RD_LATENCY = 1
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  output logic done
);

  localparam int CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY + 1) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= CW'(RD_LATENCY);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign done = (cnt == CW'(1));

endmodule

// File: rtl/otp_agent.sv
// RAM-bus pass-through agent that latches secure debug at boot and turns writes
// into the OTP window into read-back, blank-check, then program-or-reject.
module otp_agent
  import otp_agent_pkg::*;
#(
  parameter int                    BUS_WIDTH  = DEF_BUS_WIDTH,
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter logic [BUS_WIDTH-1:0]  OTP_BASE   = 'h0000_1000,
  parameter int                    OTP_WORDS  = 64,
  parameter logic [BUS_WIDTH-1:0]  CFG_ADDR   = 'h0000_1000,
  parameter logic [DATA_WIDTH-1:0] DBG_MAGIC  = DEF_DBG_MAGIC,
  parameter int                    RD_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [BUS_WIDTH-1:0]      m_ram_raddr,
  output logic [DATA_WIDTH-1:0]     m_ram_rdata,
  input  logic                      m_ram_ren,
  input  logic [BUS_WIDTH-1:0]      m_ram_waddr,
  input  logic [DATA_WIDTH-1:0]     m_ram_wdata,
  input  logic [DATA_WIDTH/8-1:0]   m_ram_wen,
  output logic                      m_ram_stall,
  output logic [BUS_WIDTH-1:0]      s_ram_raddr,
  input  logic [DATA_WIDTH-1:0]     s_ram_rdata,
  output logic                      s_ram_ren,
  output logic [BUS_WIDTH-1:0]      s_ram_waddr,
  output logic [DATA_WIDTH-1:0]     s_ram_wdata,
  output logic [DATA_WIDTH/8-1:0]   s_ram_wen,
  output logic                      secure_debug_enable,
  output logic                      otp_violation
);

  localparam int NBYTES = bytes_per_word(DATA_WIDTH);
  localparam int AW1    = BUS_WIDTH + 1;

  // One extra bit keeps a window that ends at the top of the address space from wrapping.
  localparam logic [BUS_WIDTH:0] WIN_LO = {1'b0, OTP_BASE};
  localparam logic [BUS_WIDTH:0] WIN_HI = WIN_LO + AW1'(OTP_WORDS * NBYTES);

  state_t                  state, state_nxt;
  logic [BUS_WIDTH-1:0]    lat_waddr;
  logic [DATA_WIDTH-1:0]   lat_wdata;
  logic [NBYTES-1:0]       lat_wen;
  logic                    rd_start;
  logic                    rd_done;
  logic                    in_window;
  logic                    intercept;
  logic                    blank;

  otp_agent_rdwait #(.RD_LATENCY(RD_LATENCY)) u_rdwait (
    .clk    (clk),
    .resetn (resetn),
    .start  (rd_start),
    .done   (rd_done)
  );

  assign in_window = ({1'b0, m_ram_waddr} >= WIN_LO) && ({1'b0, m_ram_waddr} < WIN_HI);
  assign intercept = (m_ram_wen != '0) && in_window;
  assign m_ram_rdata = s_ram_rdata;

  // Only lanes that will actually be programmed have to read back as zero.
  always_comb begin
    blank = 1'b1;
    for (int i = 0; i < NBYTES; i++) begin
      if (lat_wen[i] && (s_ram_rdata[8*i +: 8] != 8'h00)) blank = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state               <= BOOT_REQ;
      secure_debug_enable <= 1'b0;
      otp_violation       <= 1'b0;
      lat_waddr           <= '0;
      lat_wdata           <= '0;
      lat_wen             <= '0;
    end else begin
      state <= state_nxt;
      if (state == PASS && intercept) begin
        lat_waddr <= m_ram_waddr;
        lat_wdata <= m_ram_wdata;
        lat_wen   <= m_ram_wen;
      end
      if (state == BOOT_WAIT && rd_done) secure_debug_enable <= (s_ram_rdata == DBG_MAGIC);
      if (state == CHK_WAIT && rd_done && !blank) otp_violation <= 1'b1;
    end
  end

  // Outside PASS the slave only ever sees latched values or zero, never the live master bus.
  always_comb begin
    state_nxt   = state;
    m_ram_stall = 1'b1;
    s_ram_ren   = 1'b0;
    s_ram_raddr = '0;
    s_ram_waddr = '0;
    s_ram_wdata = '0;
    s_ram_wen   = '0;
    rd_start    = 1'b0;
    if (resetn) begin
      case (state)
        BOOT_REQ: begin
          s_ram_ren   = 1'b1;
          s_ram_raddr = CFG_ADDR;
          rd_start    = 1'b1;
          state_nxt   = BOOT_WAIT;
        end
        BOOT_WAIT: begin
          if (rd_done) state_nxt = PASS;
        end
        PASS: begin
          if (intercept) begin
            state_nxt = CHK_REQ;
          end else begin
            m_ram_stall = 1'b0;
            s_ram_ren   = m_ram_ren;
            s_ram_raddr = m_ram_raddr;
            s_ram_waddr = m_ram_waddr;
            s_ram_wdata = m_ram_wdata;
            s_ram_wen   = m_ram_wen;
          end
        end
        CHK_REQ: begin
          s_ram_ren   = 1'b1;
          s_ram_raddr = lat_waddr;
          rd_start    = 1'b1;
          state_nxt   = CHK_WAIT;
        end
        CHK_WAIT: begin
          if (rd_done) state_nxt = blank ? PROG : PASS;
        end
        PROG: begin
          s_ram_waddr = lat_waddr;
          s_ram_wdata = lat_wdata;
          s_ram_wen   = lat_wen;
          state_nxt   = PASS;
        end
        default: state_nxt = BOOT_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_otp_agent.sv
// Directed bench for otp_agent: boot latch, pass-through, window edges,
// accepted/rejected/partial OTP programs and reset in the middle of a check.
module tb_otp_agent;

  localparam logic [31:0] MAGIC = 32'hD5B6_0A11;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] m_ram_raddr, m_ram_waddr, m_ram_wdata, m_ram_rdata;
  logic        m_ram_ren, m_ram_stall;
  logic [3:0]  m_ram_wen;
  logic [31:0] s_ram_raddr, s_ram_rdata, s_ram_waddr, s_ram_wdata;
  logic        s_ram_ren;
  logic [3:0]  s_ram_wen;
  logic        secure_debug_enable, otp_violation;

  int vectors = 0;
  int miscompares = 0;

  // Slave model: byte-enabled memory with one cycle of read latency.
  logic [31:0] mem [logic [29:0]];
  int          wr_count = 0;
  logic [31:0] last_waddr, last_wdata;
  logic [3:0]  last_wen;

  always #5 clk = ~clk;

  otp_agent dut (
    .clk                 (clk),
    .resetn              (resetn),
    .m_ram_raddr         (m_ram_raddr),
    .m_ram_rdata         (m_ram_rdata),
    .m_ram_ren           (m_ram_ren),
    .m_ram_waddr         (m_ram_waddr),
    .m_ram_wdata         (m_ram_wdata),
    .m_ram_wen           (m_ram_wen),
    .m_ram_stall         (m_ram_stall),
    .s_ram_raddr         (s_ram_raddr),
    .s_ram_rdata         (s_ram_rdata),
    .s_ram_ren           (s_ram_ren),
    .s_ram_waddr         (s_ram_waddr),
    .s_ram_wdata         (s_ram_wdata),
    .s_ram_wen           (s_ram_wen),
    .secure_debug_enable (secure_debug_enable),
    .otp_violation       (otp_violation)
  );

  function automatic logic [31:0] get_word(input logic [31:0] addr);
    return mem.exists(addr[31:2]) ? mem[addr[31:2]] : 32'h0;
  endfunction

  always @(posedge clk) begin
    logic [31:0] w;
    if (s_ram_ren) s_ram_rdata <= get_word(s_ram_raddr);
    if (s_ram_wen != 4'h0) begin
      w = get_word(s_ram_waddr);
      for (int i = 0; i < 4; i++) if (s_ram_wen[i]) w[8*i +: 8] = s_ram_wdata[8*i +: 8];
      mem[s_ram_waddr[31:2]] = w;
      wr_count   <= wr_count + 1;
      last_waddr <= s_ram_waddr;
      last_wdata <= s_ram_wdata;
      last_wen   <= s_ram_wen;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_master();
    m_ram_raddr = 32'h0; m_ram_ren = 1'b0;
    m_ram_waddr = 32'h0; m_ram_wdata = 32'h0; m_ram_wen = 4'h0;
  endtask

  // Leaves the bench at +1 in the first PASS cycle.
  task automatic do_reset();
    resetn = 1'b0;
    idle_master();
    tick(); tick(); tick();
    resetn = 1'b1;
    tick(); tick();
  endtask

  // Issues one write from +1 of a PASS cycle, returns at +3 of the first unstalled cycle.
  task automatic do_otp_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w,
                              output int stalls, output logic [3:0] first_swen, output logic first_sren);
    stalls = 0;
    m_ram_waddr = a; m_ram_wdata = d; m_ram_wen = w;
    #2;
    first_swen = s_ram_wen;
    first_sren = s_ram_ren;
    while (m_ram_stall && stalls < 20) begin
      stalls++;
      tick();
      m_ram_wen = 4'h0;
      #2;
    end
  endtask

  task automatic test_reset();
    mem[30'h400] = MAGIC;
    resetn = 1'b0;
    idle_master();
    tick(); tick();
    #2;
    vectors++; if (m_ram_stall !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_stall: got %b want 1", m_ram_stall); end
    vectors++; if (s_ram_ren !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_sren: got %b want 0", s_ram_ren); end
    vectors++; if (s_ram_wen !== 4'h0) begin miscompares++; $display("[TB] FAIL rst_swen: got %h want 0", s_ram_wen); end
    vectors++; if (secure_debug_enable !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_sde: got %b want 0", secure_debug_enable); end
    vectors++; if (otp_violation !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_viol: got %b want 0", otp_violation); end
    tick();
    resetn = 1'b1;
    #2;
    vectors++; if (s_ram_ren !== 1'b1 || s_ram_raddr !== 32'h1000) begin miscompares++; $display("[TB] FAIL boot_req: got ren=%b addr=%h want ren=1 addr=00001000", s_ram_ren, s_ram_raddr); end
    tick(); #2;
    vectors++; if (m_ram_stall !== 1'b1 || secure_debug_enable !== 1'b0) begin miscompares++; $display("[TB] FAIL boot_wait: got stall=%b sde=%b want stall=1 sde=0", m_ram_stall, secure_debug_enable); end
    tick(); #2;
    vectors++; if (m_ram_stall !== 1'b0) begin miscompares++; $display("[TB] FAIL boot_pass_stall: got %b want 0", m_ram_stall); end
    vectors++; if (secure_debug_enable !== 1'b1) begin miscompares++; $display("[TB] FAIL boot_sde_on: got %b want 1", secure_debug_enable); end
  endtask

  task automatic test_boot_disable();
    int st; logic [3:0] fw; logic fr;
    mem[30'h400] = 32'h0;
    do_reset();
    #2;
    vectors++; if (secure_debug_enable !== 1'b0) begin miscompares++; $display("[TB] FAIL boot_sde_off: got %b want 0", secure_debug_enable); end
    tick();
    do_otp_write(32'h1000, MAGIC, 4'hF, st, fw, fr);
    vectors++; if (st !== 4) begin miscompares++; $display("[TB] FAIL cfg_prog_stalls: got %0d want 4", st); end
    vectors++; if (get_word(32'h1000) !== MAGIC) begin miscompares++; $display("[TB] FAIL cfg_prog_mem: got %h want %h", get_word(32'h1000), MAGIC); end
    tick(); #2;
    vectors++; if (secure_debug_enable !== 1'b0) begin miscompares++; $display("[TB] FAIL cfg_no_effect: got %b want 0", secure_debug_enable); end
    do_reset();
    #2;
    vectors++; if (secure_debug_enable !== 1'b1) begin miscompares++; $display("[TB] FAIL cfg_after_reset: got %b want 1", secure_debug_enable); end
  endtask

  task automatic test_passthrough();
    int c0;
    c0 = wr_count;
    mem[30'h401] = 32'hA5A5_5A5A;
    tick();
    m_ram_waddr = 32'h2000; m_ram_wdata = 32'hCAFE_F00D; m_ram_wen = 4'hF;
    #2;
    vectors++; if (s_ram_wen !== 4'hF || s_ram_waddr !== 32'h2000 || s_ram_wdata !== 32'hCAFE_F00D || m_ram_stall !== 1'b0)
      begin miscompares++; $display("[TB] FAIL pt_write: got wen=%h a=%h d=%h stall=%b want wen=f a=00002000 d=cafef00d stall=0", s_ram_wen, s_ram_waddr, s_ram_wdata, m_ram_stall); end
    tick();
    m_ram_wen = 4'h0;
    m_ram_raddr = 32'h1004; m_ram_ren = 1'b1;
    #2;
    vectors++; if (s_ram_ren !== 1'b1 || s_ram_raddr !== 32'h1004 || m_ram_stall !== 1'b0)
      begin miscompares++; $display("[TB] FAIL pt_read_req: got ren=%b a=%h stall=%b want ren=1 a=00001004 stall=0", s_ram_ren, s_ram_raddr, m_ram_stall); end
    tick();
    m_ram_ren = 1'b0;
    #2;
    vectors++; if (m_ram_rdata !== 32'hA5A5_5A5A) begin miscompares++; $display("[TB] FAIL pt_rdata: got %h want a5a55a5a", m_ram_rdata); end
    vectors++; if (wr_count !== c0 + 1 || get_word(32'h2000) !== 32'hCAFE_F00D) begin miscompares++; $display("[TB] FAIL pt_mem: got n=%0d d=%h want n=%0d d=cafef00d", wr_count, get_word(32'h2000), c0 + 1); end
    tick();
    m_ram_waddr = 32'h1008; m_ram_wdata = 32'hFFFF_FFFF; m_ram_wen = 4'h0;
    #2;
    vectors++; if (m_ram_stall !== 1'b0 || s_ram_wen !== 4'h0) begin miscompares++; $display("[TB] FAIL wen0_window: got stall=%b wen=%h want stall=0 wen=0", m_ram_stall, s_ram_wen); end
  endtask

  task automatic test_window_edges();
    int st; logic [3:0] fw; logic fr;
    tick();
    m_ram_waddr = 32'h0FFC; m_ram_wdata = 32'h1111_1111; m_ram_wen = 4'hF;
    #2;
    vectors++; if (m_ram_stall !== 1'b0 || s_ram_wen !== 4'hF) begin miscompares++; $display("[TB] FAIL below_window: got stall=%b wen=%h want stall=0 wen=f", m_ram_stall, s_ram_wen); end
    tick();
    m_ram_waddr = 32'h1100; m_ram_wdata = 32'h2222_2222;
    #2;
    vectors++; if (m_ram_stall !== 1'b0 || s_ram_wen !== 4'hF) begin miscompares++; $display("[TB] FAIL above_window: got stall=%b wen=%h want stall=0 wen=f", m_ram_stall, s_ram_wen); end
    tick();
    m_ram_wen = 4'h0;
    tick();
    do_otp_write(32'h10FC, 32'hDEAD_BEEF, 4'hF, st, fw, fr);
    vectors++; if (st !== 4 || fw !== 4'h0) begin miscompares++; $display("[TB] FAIL last_word: got stalls=%0d wen=%h want stalls=4 wen=0", st, fw); end
  endtask

  task automatic test_accept();
    int st, c0; logic [3:0] fw; logic fr;
    c0 = wr_count;
    tick();
    m_ram_raddr = 32'h2000; m_ram_ren = 1'b1;
    do_otp_write(32'h1008, 32'h1234_5678, 4'hF, st, fw, fr);
    vectors++; if (fw !== 4'h0 || fr !== 1'b0) begin miscompares++; $display("[TB] FAIL acc_holdoff: got wen=%h ren=%b want wen=0 ren=0", fw, fr); end
    vectors++; if (st !== 4) begin miscompares++; $display("[TB] FAIL acc_stalls: got %0d want 4", st); end
    vectors++; if (s_ram_ren !== 1'b1 || s_ram_raddr !== 32'h2000) begin miscompares++; $display("[TB] FAIL acc_reissue: got ren=%b a=%h want ren=1 a=00002000", s_ram_ren, s_ram_raddr); end
    m_ram_ren = 1'b0;
    vectors++; if (wr_count !== c0 + 1 || last_waddr !== 32'h1008 || last_wdata !== 32'h1234_5678 || last_wen !== 4'hF)
      begin miscompares++; $display("[TB] FAIL acc_write: got n=%0d a=%h d=%h w=%h want n=%0d a=00001008 d=12345678 w=f", wr_count - c0, last_waddr, last_wdata, last_wen, 1); end
    vectors++; if (otp_violation !== 1'b0) begin miscompares++; $display("[TB] FAIL acc_viol: got %b want 0", otp_violation); end
  endtask

  task automatic test_reject_and_partial();
    int st, c0; logic [3:0] fw; logic fr;
    mem[30'h403] = 32'h0000_00FF;
    c0 = wr_count;
    tick();
    do_otp_write(32'h100C, 32'h0000_0011, 4'h1, st, fw, fr);
    vectors++; if (st !== 3) begin miscompares++; $display("[TB] FAIL rej_stalls: got %0d want 3", st); end
    vectors++; if (wr_count !== c0 || get_word(32'h100C) !== 32'h0000_00FF) begin miscompares++; $display("[TB] FAIL rej_nowrite: got n=%0d d=%h want n=0 d=000000ff", wr_count - c0, get_word(32'h100C)); end
    vectors++; if (otp_violation !== 1'b1) begin miscompares++; $display("[TB] FAIL rej_viol: got %b want 1", otp_violation); end
    tick();
    do_otp_write(32'h100C, 32'h0000_AB00, 4'h2, st, fw, fr);
    vectors++; if (st !== 4 || wr_count !== c0 + 1 || last_wen !== 4'h2) begin miscompares++; $display("[TB] FAIL part_accept: got stalls=%0d n=%0d w=%h want stalls=4 n=1 w=2", st, wr_count - c0, last_wen); end
    vectors++; if (get_word(32'h100C) !== 32'h0000_ABFF) begin miscompares++; $display("[TB] FAIL part_mem: got %h want 0000abff", get_word(32'h100C)); end
    vectors++; if (otp_violation !== 1'b1) begin miscompares++; $display("[TB] FAIL viol_sticky: got %b want 1", otp_violation); end
  endtask

  task automatic test_reset_mid_op();
    int c0;
    c0 = wr_count;
    tick();
    m_ram_waddr = 32'h1010; m_ram_wdata = 32'h5555_5555; m_ram_wen = 4'hF;
    tick();
    m_ram_wen = 4'h0;
    tick();
    resetn = 1'b0;
    #2;
    vectors++; if (s_ram_wen !== 4'h0 || m_ram_stall !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_rst_out: got wen=%h stall=%b want wen=0 stall=1", s_ram_wen, m_ram_stall); end
    tick();
    resetn = 1'b1;
    #2;
    vectors++; if (s_ram_ren !== 1'b1 || s_ram_raddr !== 32'h1000 || s_ram_wen !== 4'h0)
      begin miscompares++; $display("[TB] FAIL mid_rst_boot: got ren=%b a=%h wen=%h want ren=1 a=00001000 wen=0", s_ram_ren, s_ram_raddr, s_ram_wen); end
    vectors++; if (otp_violation !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_rst_viol: got %b want 0", otp_violation); end
    tick(); tick(); #2;
    vectors++; if (m_ram_stall !== 1'b0 || secure_debug_enable !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_rst_pass: got stall=%b sde=%b want stall=0 sde=1", m_ram_stall, secure_debug_enable); end
    vectors++; if (wr_count !== c0 || get_word(32'h1010) !== 32'h0) begin miscompares++; $display("[TB] FAIL mid_rst_nowrite: got n=%0d d=%h want n=0 d=00000000", wr_count - c0, get_word(32'h1010)); end
  endtask

  initial begin
    s_ram_rdata = 32'h0;
    test_reset();
    test_boot_disable();
    test_passthrough();
    test_window_edges();
    test_accept();
    test_reject_and_partial();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
